// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receiver and transmitter.
//   rx_state_t    : receiver FSM state encoding
//   clks_per_bit(): integer clock cycles per serial bit for a given clock/baud pair
package uart_pkg;

    typedef enum logic [2:0] {
        RX_WAIT_HIGH,
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff -- two-flop synchronizer for a single asynchronous input.
//   clk       : destination clock
//   rst_n     : asynchronous active-low reset, both flops load RESET_VAL
//   d         : asynchronous input
//   q         : synchronized output (two clk edges of latency)
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with valid/ready output and sticky error flags.
//   clk       : clock, all logic on rising edge
//   rst_n     : asynchronous active-low reset
//   rx        : asynchronous serial line, idle high
//   rx_ready  : consumer accepts rx_data this cycle
//   clr_err   : one-cycle clear of frame_err and overrun
//   rx_data   : received byte (LSB first on the line)
//   rx_valid  : rx_data holds an unaccepted byte
//   rx_busy   : a frame is being received (START, DATA or STOP)
//   frame_err : sticky, stop bit sampled low
//   overrun   : sticky, byte dropped because rx_valid was still high
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 125_000_000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rx_ready,
    input  logic       clr_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST    = 16'(HALF_BIT - 1);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_baud
        $fatal(1, "uart_rx: CLK_FREQ/BAUD_RATE must be within 4..65535");
    end

    rx_state_t   state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        rxs;
    logic        deliver;
    logic        ferr_set;
    logic        ovr_set;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rxs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RX_WAIT_HIGH;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        deliver     = 1'b0;
        ferr_set    = 1'b0;
        unique case (state)
            RX_WAIT_HIGH: begin
                if (rxs) state_nxt = RX_IDLE;
            end
            RX_IDLE: begin
                if (!rxs) begin
                    state_nxt = RX_START;
                    cnt_nxt   = '0;
                end
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    // Still low at mid start bit: genuine frame; otherwise a glitch.
                    if (!rxs) begin
                        state_nxt   = RX_DATA;
                        bit_idx_nxt = '0;
                    end else begin
                        state_nxt = RX_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    // Right shift: the first (LSB) bit ends up in bit 0 after eight samples.
                    shreg_nxt = {rxs, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = RX_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    if (rxs) begin
                        deliver   = 1'b1;
                        state_nxt = RX_IDLE;
                    end else begin
                        ferr_set  = 1'b1;
                        state_nxt = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: state_nxt = RX_WAIT_HIGH;
        endcase
    end

    assign rx_busy = (state == RX_START) || (state == RX_DATA) || (state == RX_STOP);

    // A new byte is dropped only if the previous one is still held and not taken this cycle.
    assign ovr_set = deliver && rx_valid && !rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (ferr_set) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end

            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- scoreboard bench for uart_rx at 10 clocks per bit.
//   Stimulus pushes expected bytes into exp_q; a negedge monitor pops and
//   compares on every rx_valid/rx_ready handshake.
module tb_uart_rx;

    localparam int unsigned CLK_FREQ  = 1_000_000;
    localparam int unsigned BAUD_RATE = 100_000;
    localparam int unsigned BIT       = CLK_FREQ / BAUD_RATE;   // 10
    localparam int unsigned HALF      = BIT / 2;                // 5
    // rx change -> valid: two synchronizer edges, one IDLE detection edge,
    // then half a start bit plus eight data bits plus the stop bit.
    localparam int unsigned LATENCY   = 3 + HALF + 9 * BIT;     // 98

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rx_ready;
    logic       clr_err;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int         vectors    = 0;
    int         miscompares = 0;
    int         cyc        = 0;
    int         rise_cnt   = 0;
    int         high_cnt   = 0;
    int         last_rise_cyc = 0;
    logic       prev_valid = 1'b0;
    logic       rand_ready = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_ready  (rx_ready),
        .clr_err   (clr_err),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: handshakes are compared against the scoreboard queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && !prev_valid) begin
                rise_cnt      = rise_cnt + 1;
                last_rise_cyc = cyc;
            end
            if (rx_valid) high_cnt = high_cnt + 1;
            if (rx_valid && rx_ready) begin
                vectors = vectors + 1;
                if (exp_q.size() == 0) begin
                    miscompares = miscompares + 1;
                    $display("FAIL byte: unexpected delivery actual=%02h required=none", rx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        miscompares = miscompares + 1;
                        $display("FAIL byte: actual=%02h required=%02h", rx_data, e);
                    end
                end
            end
        end
        prev_valid = rx_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
    endtask

    // One 8N1 frame: start bit, data LSB first, stop bit, then line idle.
    task automatic send(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (BIT) tick();
        end
        rx = 1'b1;
    endtask

    initial begin
        int t_start;
        int drained;
        logic saw_busy;
        logic [7:0] b;
        logic [7:0] abort_byte;

        rst_n = 1'b0; rx = 1'b1; rx_ready = 1'b0; clr_err = 1'b0;
        #1;
        chk("reset_valid", {31'd0, rx_valid}, 0);
        chk("reset_data", {24'd0, rx_data}, 0);
        chk("reset_busy", {31'd0, rx_busy}, 0);
        chk("reset_flags", {30'd0, frame_err, overrun}, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();

        // 0xA5 held with rx_ready low, then one-cycle accept.
        exp_q.push_back(8'hA5);
        t_start = cyc;
        send(8'hA5, 1'b1);
        repeat (20) tick();
        chk("a5_latency", 32'(last_rise_cyc - t_start), LATENCY);
        chk("a5_held_valid", {31'd0, rx_valid}, 1);
        chk("a5_held_data", {24'd0, rx_data}, 32'hA5);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("a5_cleared", {31'd0, rx_valid}, 0);

        // 3-cycle low glitch on an idle line.
        rx_ready = 1'b1;
        rx = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) rx = 1'b1;
            tick();
            saw_busy = saw_busy | rx_busy;
        end
        chk("glitch_busy_pulse", {31'd0, saw_busy}, 1);
        chk("glitch_idle", {29'd0, rx_busy, rx_valid, frame_err | overrun}, 0);

        // Framing error on 0x3C, then 0x55, then clear.
        send(8'h3C, 1'b0);
        chk("ferr_set", {31'd0, frame_err}, 1);
        chk("ferr_no_valid", {31'd0, rx_valid}, 0);
        repeat (2 * BIT) tick();
        exp_q.push_back(8'h55);
        send(8'h55, 1'b1);
        repeat (5) tick();
        chk("ferr_sticky", {31'd0, frame_err}, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ferr_cleared", {31'd0, frame_err}, 0);

        // Overrun: 0x01 then 0x02 back-to-back, nothing accepted.
        rx_ready = 1'b0;
        exp_q.push_back(8'h01);
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        tick();
        chk("ovr_valid", {31'd0, rx_valid}, 1);
        chk("ovr_data_kept", {24'd0, rx_data}, 32'h01);
        chk("ovr_set", {31'd0, overrun}, 1);

        // Reset in the middle of data bit 3 of 0x96; pending byte is lost.
        abort_byte = 8'h96;
        rx = 1'b0;
        repeat (BIT) tick();
        for (int i = 0; i < 4; i++) begin
            rx = abort_byte[i];
            repeat (i == 3 ? HALF : BIT) tick();
        end
        chk("midframe_busy", {31'd0, rx_busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_valid", {31'd0, rx_valid}, 0);
        chk("mid_reset_data", {24'd0, rx_data}, 0);
        chk("mid_reset_busy", {31'd0, rx_busy}, 0);
        chk("mid_reset_flags", {30'd0, frame_err, overrun}, 0);
        exp_q.delete();
        rx = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3 * BIT) tick();
        rx_ready = 1'b1;
        exp_q.push_back(8'hFF);
        send(8'hFF, 1'b1);
        repeat (5) tick();

        // Delivery of 0x02 coincides with acceptance of 0x01: no overrun.
        rx_ready = 1'b0;
        exp_q.push_back(8'h01);
        send(8'h01, 1'b1);
        exp_q.push_back(8'h02);
        fork
            send(8'h02, 1'b1);
            begin
                repeat (LATENCY - 1) tick();
                rx_ready = 1'b1;
                tick();
                rx_ready = 1'b0;
            end
        join
        tick();
        chk("coincide_valid", {31'd0, rx_valid}, 1);
        chk("coincide_data", {24'd0, rx_data}, 32'h02);
        chk("coincide_no_ovr", {31'd0, overrun}, 0);
        rx_ready = 1'b1;
        tick();
        chk("coincide_cleared", {31'd0, rx_valid}, 0);

        // 0x00 and 0xFF back-to-back with rx_ready held high.
        rise_cnt = 0;
        high_cnt = 0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        repeat (5) tick();
        chk("b2b_pulses", 32'(rise_cnt), 2);
        chk("b2b_pulse_width", 32'(high_cnt), 2);
        chk("b2b_no_errors", {30'd0, frame_err, overrun}, 0);

        // Random bytes, random idle gaps, random consumer backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send(b, 1'b1);
            repeat ($urandom_range(0, 12)) tick();
        end
        rand_ready = 1'b0;
        rx_ready = 1'b1;

        drained = 0;
        for (int i = 0; i < 300 && !drained; i++) begin
            tick();
            if (exp_q.size() == 0) drained = 1;
        end
        chk("drain_all_bytes", 32'(exp_q.size()), 0);
        chk("final_flags", {30'd0, frame_err, overrun}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 125_000_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning serial bit rate.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rx_ready  input  1  consumer accepts rx_data this cycle.
REQ-007 SHALL have port clr_err  input  1  one-cycle clear of frame_err and overrun.
REQ-008 SHALL have port rx_data  output  8  received byte, LSB first on the line.
REQ-009 SHALL have port rx_valid  output  1  rx_data holds an unaccepted byte.
REQ-010 SHALL have port rx_busy  output  1  frame reception in progress (state START, DATA or STOP).
REQ-011 SHALL have port frame_err  output  1  sticky: stop bit sampled low.
REQ-012 SHALL have port overrun  output  1  sticky: byte dropped because rx_valid was still high.

Function
REQ-013 SHALL derive CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer) and HALF_BIT = CLKS_PER_BIT/2.
REQ-014 SHALL fail elaboration unless 4 <= CLKS_PER_BIT <= 65535; the bit counter is 16 bits wide.
REQ-015 SHALL pass rx through a 2-flop synchronizer (flops reset to 1); all decisions use the synchronized value rxs.
REQ-016 SHALL implement states WAIT_HIGH, IDLE, START, DATA, STOP.
REQ-017 WAIT_HIGH: stay while rxs=0; go to IDLE on the first cycle rxs=1.
REQ-018 IDLE: on rxs=0 go to START and clear the counter; the cycle of this transition is t0.
REQ-019 START: at counter = HALF_BIT-1, if rxs=0 go to DATA with counter cleared and bit index 0; if rxs=1 (glitch) go to IDLE with no output change.
REQ-020 DATA: at counter = CLKS_PER_BIT-1, shift rxs into the shift register as bit[index], LSB first; after index 7 go to STOP.
REQ-021 STOP: at counter = CLKS_PER_BIT-1 sample rxs; if 1 deliver the byte and go to IDLE; if 0 set frame_err, discard the byte and go to WAIT_HIGH.
REQ-022 Counter SHALL increment every cycle in START/DATA/STOP and clear on every state or bit transition.
REQ-023 Delivery SHALL register rx_data and set rx_valid on the edge after the stop-bit sample, i.e. HALF_BIT + 9*CLKS_PER_BIT cycles after t0.
REQ-024 rx_valid SHALL stay high and rx_data stable until a cycle with rx_valid=1 and rx_ready=1; rx_valid then clears on the next edge.
REQ-025 If delivery coincides with acceptance, rx_data SHALL load the new byte, rx_valid SHALL stay 1, and overrun SHALL NOT set.
REQ-026 If delivery occurs while rx_valid=1 with no acceptance, the new byte SHALL be dropped, rx_data SHALL be kept, and overrun SHALL set.
REQ-027 clr_err SHALL clear both flags on the next edge; a simultaneous set event SHALL win over clr_err.
REQ-028 rx_ready while rx_valid=0 SHALL have no effect.

Reset
REQ-029 Asserting rst_n low SHALL immediately give state WAIT_HIGH, synchronizer=11, counter=0, shift register=0, rx_data=0x00, rx_valid=0, rx_busy=0, frame_err=0, overrun=0.
REQ-030 Reset mid-frame SHALL abandon the partial byte; reception resumes only after rxs is seen high.

Structure
REQ-031 Package uart_pkg SHALL hold the rx state enum and a function computing CLKS_PER_BIT; the same package serves uart_tx.
REQ-032 The synchronizer SHALL be a separate sub-module, sync_2ff, with its reset value as a parameter.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000: CLKS_PER_BIT=10, HALF_BIT=5)
REQ-033 Send 0xA5 with rx_ready=0 -> rx_valid rises 95 cycles after t0 with rx_data=0xA5, held until rx_ready pulse, then clears the next cycle.
REQ-034 Drive rx low for 3 cycles only -> rx_busy pulses; no rx_valid; flags stay 0; state returns to IDLE.
REQ-035 Send 0x3C with stop bit 0, then line high, then 0x55 -> frame_err=1 with no rx_valid for 0x3C; 0x55 delivered correctly; clr_err clears frame_err.
REQ-036 Send 0x01 then 0x02 back-to-back with rx_ready=0 -> rx_data=0x01, overrun=1; rx_ready held 1 on the delivery cycle of 0x02 instead -> rx_data=0x02, overrun=0.
REQ-037 Assert rst_n mid-bit-3 of 0x96 -> all outputs are at reset values; the following 0xFF is received correctly.
REQ-038 Send 0x00 and 0xFF back-to-back with rx_ready=1 -> two one-cycle rx_valid pulses with correct data; no errors.
